// File: rtl/fmps_test_burst_gen.sv
// FMPS test-link burst source: one header+data packet per enabled channel on each FA strobe.
// Define FMPS_TEST_LFSR_EN to replace the counter data pattern with a 32-bit LFSR sequence.
module fmps_test_burst_gen #(
    parameter int          NUM_CHANNELS    = 2,
    parameter int          INDEX_WIDTH     = 5,
    parameter int          INDEX_START_BIT = 10,
    parameter int          FIRST_INDEX     = 0,
    parameter int          NUM_DATA_WORDS  = 1,
    parameter logic [15:0] MAGIC           = 16'hB6CF
) (
    input  logic                    auroraUserClk,
    input  logic                    auroraReset,
    input  logic                    auroraFAstrobe,
    input  logic                    auroraChannelUp,
    input  logic                    cfgEnable,
    input  logic [NUM_CHANNELS-1:0] cfgChannelMask,
    input  logic                    cfgStatusClear,
    output logic [31:0]             FMPS_TEST_AXI_STREAM_TX_tdata,
    output logic                    FMPS_TEST_AXI_STREAM_TX_tvalid,
    output logic                    FMPS_TEST_AXI_STREAM_TX_tlast,
    input  logic                    FMPS_TEST_AXI_STREAM_TX_tready,
    output logic                    busy,
    output logic                    overrun,
    output logic [31:0]             packetCount,
    output logic [15:0]             cycleCount
);

    localparam int         CW        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [7:0] LAST_WORD = 8'(NUM_DATA_WORDS);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t                  state;
    logic [NUM_CHANNELS-1:0] pending;
    logic [CW-1:0]           chan;
    logic [7:0]              word_idx;

    logic [CW-1:0]           first_chan;
    logic [CW-1:0]           next_chan;
    logic [NUM_CHANNELS-1:0] first_rest;
    logic [NUM_CHANNELS-1:0] next_rest;
    logic [7:0]              next_word;
    logic [31:0]             data_next;
    logic [15:0]             cycle_inc;
    logic                    handshake;

    function automatic logic [CW-1:0] lowest_set(input logic [NUM_CHANNELS-1:0] m);
        logic [CW-1:0] r;
        r = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (m[i]) r = CW'(i);
        return r;
    endfunction

    function automatic logic [31:0] header_word(input logic [CW-1:0] c, input logic [15:0] cyc);
        logic [31:0] h;
        h = '0;
        h[31:16] = MAGIC;
        h[9:0] = cyc[9:0];
        h[INDEX_START_BIT +: INDEX_WIDTH] = INDEX_WIDTH'(FIRST_INDEX + int'(c));
        return h;
    endfunction

    always_comb begin
        first_chan = lowest_set(cfgChannelMask);
        next_chan  = lowest_set(pending);
        first_rest = cfgChannelMask & ~(NUM_CHANNELS'(1) << first_chan);
        next_rest  = pending & ~(NUM_CHANNELS'(1) << next_chan);
        next_word  = (state == HEADER) ? 8'd1 : word_idx + 8'd1;
        cycle_inc  = cycleCount + 16'd1;
        handshake  = FMPS_TEST_AXI_STREAM_TX_tvalid && FMPS_TEST_AXI_STREAM_TX_tready;
    end

`ifdef FMPS_TEST_LFSR_EN
    logic [31:0] lfsr;
    logic [31:0] lfsr_step;

    // XNOR feedback keeps the seed-1 sequence starting 1, 2, 4, ...
    assign lfsr_step = {lfsr[30:0], ~(lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0])};
    assign data_next = (state == DATA) ? lfsr_step : lfsr;

    always_ff @(posedge auroraUserClk) begin
        if (auroraReset)
            lfsr <= 32'h1;
        else if (state == DATA && handshake && auroraChannelUp)
            lfsr <= lfsr_step;
    end
`else
    assign data_next = {8'(FIRST_INDEX + int'(chan)), next_word, cycleCount};
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge auroraUserClk) begin
        if (auroraReset) begin
            state                          <= IDLE;
            pending                        <= '0;
            chan                           <= '0;
            word_idx                       <= '0;
            FMPS_TEST_AXI_STREAM_TX_tdata  <= '0;
            FMPS_TEST_AXI_STREAM_TX_tvalid <= 1'b0;
            FMPS_TEST_AXI_STREAM_TX_tlast  <= 1'b0;
            overrun                        <= 1'b0;
            packetCount                    <= '0;
            cycleCount                     <= '0;
        end else begin
            // Later assignments in this block override the clear (set wins).
            if (cfgStatusClear) begin
                overrun     <= 1'b0;
                packetCount <= '0;
            end
            case (state)
                IDLE: begin
                    if (auroraFAstrobe && cfgEnable && auroraChannelUp) begin
                        cycleCount <= cycle_inc;
                        if (cfgChannelMask != '0) begin
                            chan                           <= first_chan;
                            pending                        <= first_rest;
                            state                          <= HEADER;
                            FMPS_TEST_AXI_STREAM_TX_tdata  <= header_word(first_chan, cycle_inc);
                            FMPS_TEST_AXI_STREAM_TX_tvalid <= 1'b1;
                            FMPS_TEST_AXI_STREAM_TX_tlast  <= 1'b0;
                        end
                    end
                end
                HEADER, DATA: begin
                    if (auroraFAstrobe)
                        overrun <= 1'b1;
                    if (!auroraChannelUp) begin
                        state                          <= IDLE;
                        pending                        <= '0;
                        FMPS_TEST_AXI_STREAM_TX_tdata  <= '0;
                        FMPS_TEST_AXI_STREAM_TX_tvalid <= 1'b0;
                        FMPS_TEST_AXI_STREAM_TX_tlast  <= 1'b0;
                    end else if (handshake) begin
                        if (state == DATA && FMPS_TEST_AXI_STREAM_TX_tlast) begin
                            packetCount <= (cfgStatusClear ? 32'd0 : packetCount) + 32'd1;
                            if (pending != '0) begin
                                chan                          <= next_chan;
                                pending                       <= next_rest;
                                state                         <= HEADER;
                                FMPS_TEST_AXI_STREAM_TX_tdata <= header_word(next_chan, cycleCount);
                                FMPS_TEST_AXI_STREAM_TX_tlast <= 1'b0;
                            end else begin
                                state                          <= IDLE;
                                FMPS_TEST_AXI_STREAM_TX_tdata  <= '0;
                                FMPS_TEST_AXI_STREAM_TX_tvalid <= 1'b0;
                                FMPS_TEST_AXI_STREAM_TX_tlast  <= 1'b0;
                            end
                        end else begin
                            state                         <= DATA;
                            word_idx                      <= next_word;
                            FMPS_TEST_AXI_STREAM_TX_tdata <= data_next;
                            FMPS_TEST_AXI_STREAM_TX_tlast <= (next_word == LAST_WORD);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmps_test_burst_gen.sv
// Self-checking bench for fmps_test_burst_gen: randomized traffic against a beat-queue reference model.
module tb_fmps_test_burst_gen;

    localparam int NCH = 2;
    localparam int NDW = 3;
    localparam int ISB = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             strobe;
    logic             chan_up;
    logic             enable;
    logic [NCH-1:0]   mask;
    logic             clear;
    logic [31:0]      tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;
    logic             busy;
    logic             overrun;
    logic [31:0]      packet_count;
    logic [15:0]      cycle_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fmps_test_burst_gen #(.NUM_CHANNELS(NCH), .NUM_DATA_WORDS(NDW)) dut (
        .auroraUserClk                  (clk),
        .auroraReset                    (rst),
        .auroraFAstrobe                 (strobe),
        .auroraChannelUp                (chan_up),
        .cfgEnable                      (enable),
        .cfgChannelMask                 (mask),
        .cfgStatusClear                 (clear),
        .FMPS_TEST_AXI_STREAM_TX_tdata  (tdata),
        .FMPS_TEST_AXI_STREAM_TX_tvalid (tvalid),
        .FMPS_TEST_AXI_STREAM_TX_tlast  (tlast),
        .FMPS_TEST_AXI_STREAM_TX_tready (tready),
        .busy                           (busy),
        .overrun                        (overrun),
        .packetCount                    (packet_count),
        .cycleCount                     (cycle_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of the beats still owed on the stream plus the status counters.
    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        is_data;
    } beat_t;

    beat_t       q[$];
    logic [15:0] m_cyc  = '0;
    logic [31:0] m_pkt  = '0;
    logic        m_over = 1'b0;
    logic [31:0] m_lfsr = 32'h1;

    function automatic logic [31:0] exp_data(input beat_t b);
`ifdef FMPS_TEST_LFSR_EN
        if (b.is_data) return m_lfsr;
`endif
        return b.data;
    endfunction

    always @(negedge clk) begin
        logic  was_busy;
        beat_t b;
        // compare state left by the previous edge
        check("busy", 32'(busy), 32'(q.size() != 0));
        check("tvalid", 32'(tvalid), 32'(q.size() != 0));
        if (tvalid && q.size() != 0) begin
            check("tdata", tdata, exp_data(q[0]));
            check("tlast", 32'(tlast), 32'(q[0].last));
        end
        check("cycleCount", 32'(cycle_count), 32'(m_cyc));
        check("packetCount", packet_count, m_pkt);
        check("overrun", 32'(overrun), 32'(m_over));

        // advance the model to what the coming edge should produce
        if (rst) begin
            q.delete();
            m_cyc = '0; m_pkt = '0; m_over = 1'b0; m_lfsr = 32'h1;
        end else begin
            was_busy = (q.size() != 0);
            if (clear) begin
                m_pkt  = '0;
                m_over = 1'b0;
            end
            if (was_busy) begin
                if (strobe) m_over = 1'b1;
                if (!chan_up) q.delete();
                else if (tready) begin
                    b = q.pop_front();
                    if (b.last) m_pkt = m_pkt + 1;
                    if (b.is_data) m_lfsr = {m_lfsr[30:0], ~(m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0])};
                end
            end else if (strobe && enable && chan_up) begin
                m_cyc = m_cyc + 1;
                for (int c = 0; c < NCH; c++) begin
                    if (mask[c]) begin
                        b.data    = 32'hB6CF_0000 | (32'(c) << ISB) | 32'(m_cyc[9:0]);
                        b.last    = 1'b0;
                        b.is_data = 1'b0;
                        q.push_back(b);
                        for (int w = 1; w <= NDW; w++) begin
                            b.data    = {8'(c), 8'(w), m_cyc};
                            b.last    = (w == NDW);
                            b.is_data = 1'b1;
                            q.push_back(b);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; strobe = 1'b0; chan_up = 1'b1; enable = 1'b1;
        mask = '0; clear = 1'b0; tready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_pkt", packet_count, 32'd0);
        check("reset_cyc", 32'(cycle_count), 32'd0);

        // Directed burst: both channels, sink always ready.
        mask = 2'b11; strobe = 1'b1;
        step();
        strobe = 1'b0;
        check("dir_hdr0", tdata, 32'hB6CF_0001);
        step();
        check("dir_data0", tdata, 32'h0001_0001);
        repeat (6) step();
        check("dir_busy_hi", 32'(busy), 32'd1);
        step();
        check("dir_busy_lo", 32'(busy), 32'd0);
        check("dir_pkt", packet_count, 32'd2);
        check("dir_cyc", 32'(cycle_count), 32'd1);

        // Randomized traffic: stalls, masks, overruns, clears, link drops, resets.
        for (int i = 0; i < 4000; i++) begin
            tready  = 1'($urandom_range(0, 1));
            strobe  = ($urandom_range(0, 7) == 0);
            mask    = NCH'($urandom);
            enable  = ($urandom_range(0, 15) != 0);
            chan_up = ($urandom_range(0, 39) != 0);
            if (!chan_up) tready = 1'b0;
            clear   = ($urandom_range(0, 29) == 0);
            rst     = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0; strobe = 1'b0; clear = 1'b0; chan_up = 1'b1; enable = 1'b1; tready = 1'b1;
        repeat (40) step();
        check("drain_busy", 32'(busy), 32'd0);

        // Overrun and status clear with a stalled sink.
        clear = 1'b1; step(); clear = 1'b0;
        mask = 2'b10; tready = 1'b0; strobe = 1'b1;
        step();
        check("ovr_hdr1", tdata, {16'hB6CF, 6'b000001, cycle_count[9:0]});
        step();
        strobe = 1'b0;
        step();
        check("ovr_set", 32'(overrun), 32'd1);
        clear = 1'b1; step(); clear = 1'b0;
        check("clr_ovr", 32'(overrun), 32'd0);
        check("clr_pkt", packet_count, 32'd0);
        clear = 1'b1; strobe = 1'b1; step(); clear = 1'b0; strobe = 1'b0;
        check("clr_set_wins", 32'(overrun), 32'd1);
        tready = 1'b1;
        repeat (10) step();
        check("final_pkt", packet_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
